// File: rtl/src_switch_ctrl_pkg.sv
// Shared types and defaults for the HDMI source switch controller.
// Imported by the edge synchronizer and the controller top.
package src_switch_ctrl_pkg;

  localparam int TIMEOUT_W_DEF   = 20;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_OLD = 3'd1,
    ST_SWITCH   = 3'd2,
    ST_WAIT_NEW = 3'd3,
    ST_UNMUTE   = 3'd4
  } state_e;

endpackage

// File: rtl/src_switch_ctrl_vs_edge_sync.sv
// VSYNC synchronizer with registered falling-edge pulse.
// Pulse rises STAGES+1 clocks after the input edge.
module vs_edge_sync
  import src_switch_ctrl_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic vs_n,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              last_q;
  logic              last_d;
  logic              fall_q;
  logic              fall_d;

  // shift chain plus delayed copy for edge detect
  always_comb begin
    sync_d[0] = vs_n;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    last_d = sync_q[STAGES-1];
    fall_d = last_q & ~sync_q[STAGES-1];
  end

  // chain resets to the inactive (high) VSYNC level
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      last_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      fall_q <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/src_switch_ctrl.sv
// Frame-aligned HDMI source switch: mute on old VSYNC,
// swap mux, stay muted for N new-source frames.
module src_switch_ctrl
  import src_switch_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       clk27,
  input  logic       reset_n,
  input  logic       sel_req,
  input  logic       vs_sc,
  input  logic       vs_vg,
  input  logic [3:0] mute_frames,
  output logic       sel,
  output logic       mute,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [TIMEOUT_W-1:0] TO_MAX = '1;

  state_e               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 mute_q, mute_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 tgt_q, tgt_d;
  logic [3:0]           frm_q, frm_d;
  logic [TIMEOUT_W-1:0] to_q, to_d;

  logic sc_fall;
  logic vg_fall;
  logic ev;
  logic to_hit;

  vs_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sc (
    .clk27   (clk27),
    .reset_n (reset_n),
    .vs_n    (vs_sc),
    .fall    (sc_fall)
  );

  vs_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_vg (
    .clk27   (clk27),
    .reset_n (reset_n),
    .vs_n    (vs_vg),
    .fall    (vg_fall)
  );

  // sel already points at the new source during WAIT_NEW
  assign ev     = sel_q ? vg_fall : sc_fall;
  assign to_hit = (to_q == TO_MAX) && !ev;

  // next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mute_d  = mute_q;
    busy_d  = busy_q;
    err_d   = err_q;
    tgt_d   = tgt_q;
    frm_d   = frm_q;
    to_d    = to_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_req != sel_q) begin
          state_d = ST_WAIT_OLD;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          tgt_d   = sel_req;
          to_d    = '0;
        end else begin
          mute_d = 1'b0;
        end
      end
      ST_WAIT_OLD: begin
        if (ev || to_hit) begin
          state_d = ST_SWITCH;
          mute_d  = 1'b1;
          if (to_hit) err_d = 1'b1;
        end else if (to_q != TO_MAX) begin
          to_d = to_q + TIMEOUT_W'(1);
        end
      end
      ST_SWITCH: begin
        state_d = ST_WAIT_NEW;
        sel_d   = tgt_q;
        frm_d   = mute_frames;
        to_d    = '0;
      end
      ST_WAIT_NEW: begin
        if (ev) begin
          to_d = '0;
          if (frm_q == 4'd0) begin
            state_d = ST_UNMUTE;
            mute_d  = 1'b0;
            busy_d  = 1'b0;
          end else begin
            frm_d = frm_q - 4'd1;
          end
        end else if (to_hit) begin
          state_d = ST_UNMUTE;
          mute_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (to_q != TO_MAX) begin
          to_d = to_q + TIMEOUT_W'(1);
        end
      end
      ST_UNMUTE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // all state and outputs; reset mutes and aborts any sequence
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      mute_q  <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      tgt_q   <= 1'b0;
      frm_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mute_q  <= mute_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
      frm_q   <= frm_d;
      to_q    <= to_d;
    end
  end

  assign sel         = sel_q;
  assign mute        = mute_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
